gray_position_decoder: RTL and testbench



---
 rtl/gray_pkg.sv | 37 +++
 rtl/gray_to_bin.sv | 18 +
 rtl/gray_position_decoder.sv | 142 ++++++++++++++
 tb/tb_gray_position_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray position decoder.
//   state_t   : FILL / LOAD / TRACK sequencing of the decoder
//   gray2bin  : Gray -> binary for a code of width w (w <= 32)
//   bin2gray  : binary -> Gray (reference helper for benches)
//   popcount  : number of set bits in a 32-bit word
package gray_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        LOAD  = 2'd1,
        TRACK = 2'd2
    } state_t;

    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
        logic [31:0] m;
        logic [31:0] x;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = g & m;
        // Prefix XOR from the MSB down, done in log2 doubling steps.
        for (int s = 1; s < 32; s = s * 2)
            x = x ^ (x >> s);
        return x;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] popcount(input logic [31:0] x);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++)
            n = n + 32'(x[i]);
        return n;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray -> binary converter.
//   i_g : Gray-coded input, W bits
//   o_b : binary output, W bits
// Bit i of the result is the XOR of all Gray bits from the MSB down to i,
// i.e. the prefix chain b[i] = b[i+1] ^ g[i] written without a
// self-referencing vector.
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_g,
    output logic [W-1:0] o_b
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_b[i] = ^i_g[W-1:i];
    end

endmodule

// File: rtl/gray_position_decoder.sv
// Gray-coded position decoder: synchronises an asynchronous Gray input,
// converts it to binary, reports legal single-step motion with direction,
// counts revolution wraps and counts/flags illegal multi-bit jumps.
//   clk, rst_n : clock, async active-low reset
//   g          : async Gray position (W bits)
//   clr        : sync clear of turns and err_cnt
//   b          : registered binary position
//   valid      : b holds a decoded sample
//   step/err   : one-cycle pulses, legal step / illegal jump
//   dir        : direction of last step (1 = up), held between steps
//   turns      : signed revolution count mod 2^TW
//   err_cnt    : saturating illegal-jump count
module gray_position_decoder
    import gray_pkg::*;
#(
    parameter int W  = 4,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  g,
    input  logic          clr,
    output logic [W-1:0]  b,
    output logic          valid,
    output logic          step,
    output logic          dir,
    output logic          err,
    output logic [TW-1:0] turns,
    output logic [TW-1:0] err_cnt
);

    logic [W-1:0]  r_s1, r_s2, r_gprev, r_b;
    logic          r_valid, r_step, r_dir, r_err;
    logic [TW-1:0] r_turns, r_err_cnt;
    logic [1:0]    r_fill, w_fill_nxt;
    state_t        r_state, w_state_nxt;

    logic [W-1:0]  w_nb;
    logic [31:0]   w_hd;
    logic          w_up, w_wrap_up, w_wrap_dn;

    // Two-flop synchroniser; the only entry point for g.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= g;
            r_s2 <= r_s1;
        end
    end

    gray_to_bin #(.W(W)) u_g2b (
        .i_g (r_s2),
        .o_b (w_nb)
    );

    assign w_hd      = popcount(32'(r_s2 ^ r_gprev));
    assign w_up      = (w_nb == r_b + W'(1));
    assign w_wrap_up = (r_b == '1) && (w_nb == '0);
    assign w_wrap_dn = (r_b == '0) && (w_nb == '1);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    // Let the synchroniser fill with real samples before the first load.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        case (r_state)
            FILL: begin
                if (r_fill == 2'd2) w_state_nxt = LOAD;
                else                w_fill_nxt  = r_fill + 2'd1;
            end
            LOAD:    w_state_nxt = TRACK;
            TRACK:   w_state_nxt = TRACK;
            default: w_state_nxt = FILL;
        endcase
    end

    // Output / tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gprev   <= '0;
            r_b       <= '0;
            r_valid   <= 1'b0;
            r_step    <= 1'b0;
            r_dir     <= 1'b0;
            r_err     <= 1'b0;
            r_turns   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_step <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_b     <= w_nb;
                    r_gprev <= r_s2;
                    r_valid <= 1'b1;
                end
                TRACK: begin
                    if (w_hd == 32'd1) begin
                        r_step  <= 1'b1;
                        r_dir   <= w_up;
                        r_b     <= w_nb;
                        r_gprev <= r_s2;
                        if (w_wrap_up)      r_turns <= r_turns + TW'(1);
                        else if (w_wrap_dn) r_turns <= r_turns - TW'(1);
                    end else if (w_hd > 32'd1) begin
                        r_err   <= 1'b1;
                        r_b     <= w_nb;
                        r_gprev <= r_s2;
                        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
            // Clear overrides any same-cycle wrap or error increment.
            if (clr) begin
                r_turns   <= '0;
                r_err_cnt <= '0;
            end
        end
    end

    assign b       = r_b;
    assign valid   = r_valid;
    assign step    = r_step;
    assign dir     = r_dir;
    assign err     = r_err;
    assign turns   = r_turns;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_gray_position_decoder.sv
// Directed bench for gray_position_decoder (W=4, TW=8).
module tb_gray_position_decoder;

    logic       clk, rst_n, clr;
    logic [3:0] g;
    logic [3:0] b;
    logic       valid, step, dir, err;
    logic [7:0] turns, err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    gray_position_decoder #(.W(4), .TW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g       (g),
        .clr     (clr),
        .b       (b),
        .valid   (valid),
        .step    (step),
        .dir     (dir),
        .err     (err),
        .turns   (turns),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic       clr;
        logic [3:0] b;
        logic       step;
        logic       dir;
        logic       err;
        logic [7:0] turns;
        logic [7:0] ec;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".b"},     32'(b),       0);
        chk({tag, ".valid"}, 32'(valid),   0);
        chk({tag, ".step"},  32'(step),    0);
        chk({tag, ".dir"},   32'(dir),     0);
        chk({tag, ".err"},   32'(err),     0);
        chk({tag, ".turns"}, 32'(turns),   0);
        chk({tag, ".ecnt"},  32'(err_cnt), 0);
    endtask

    initial begin
        int n_err_p, n_step_p;
        //            g        clr   b      stp  dir  err  turns  ec
        vt[0]  = '{4'b0010, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        vt[1]  = '{4'b0011, 1'b0, 4'd2,  1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        vt[2]  = '{4'b0001, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        vt[3]  = '{4'b0000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        vt[4]  = '{4'b0001, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0, 8'h00, 8'd0};
        vt[5]  = '{4'b0011, 1'b0, 4'd2,  1'b1, 1'b1, 1'b0, 8'h00, 8'd0};
        vt[6]  = '{4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 8'h00, 8'd0};
        vt[7]  = '{4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 8'h00, 8'd1};
        vt[8]  = '{4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b1, 8'h00, 8'd2};
        vt[9]  = '{4'b0001, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 8'h00, 8'd2};
        vt[10] = '{4'b0000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8'h00, 8'd2};
        vt[11] = '{4'b1000, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 8'hFF, 8'd2};
        vt[12] = '{4'b0000, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 8'h00, 8'd2};
        vt[13] = '{4'b1000, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        vt[14] = '{4'b0000, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 8'h01, 8'd0};
        vt[15] = '{4'b1000, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        vt[16] = '{4'b1001, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        vt[17] = '{4'b1000, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 8'h00, 8'd0};
        vt[18] = '{4'b0000, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 8'h00, 8'd0};
        vt[19] = '{4'b1000, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 8'hFF, 8'd0};

        // Reset and initial load with g held at 0110 (binary 4).
        rst_n = 1'b0;
        clr   = 1'b0;
        g     = 4'b0110;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("load.valid@%0d", k), 32'(valid), 32'(k == 4));
            chk($sformatf("load.step@%0d", k),  32'(step),  0);
        end
        chk("load.b",     32'(b),     32'd4);
        chk("load.turns", 32'(turns), 0);

        // Table: each g change lands on the outputs three edges later; clr is
        // presented for the edge on which that update happens.
        for (int i = 0; i < 20; i++) begin
            g = vt[i].g;
            @(negedge clk);
            @(negedge clk);
            clr = vt[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d.b", i),     32'(b),       32'(vt[i].b));
            chk($sformatf("v%0d.step", i),  32'(step),    32'(vt[i].step));
            chk($sformatf("v%0d.dir", i),   32'(dir),     32'(vt[i].dir));
            chk($sformatf("v%0d.err", i),   32'(err),     32'(vt[i].err));
            chk($sformatf("v%0d.turns", i), 32'(turns),   32'(vt[i].turns));
            chk($sformatf("v%0d.ecnt", i),  32'(err_cnt), 32'(vt[i].ec));
            clr = 1'b0;
        end

        // 300 back-to-back illegal jumps: one err per cycle, counter saturates.
        n_err_p  = 0;
        n_step_p = 0;
        g = 4'b0011;
        for (int i = 0; i < 303; i++) begin
            @(negedge clk);
            if (err)  n_err_p++;
            if (step) n_step_p++;
            if (i < 299) g = (i % 2 == 0) ? 4'b0000 : 4'b0011;
        end
        chk("sat.err_pulses",  32'(n_err_p),  32'd300);
        chk("sat.step_pulses", 32'(n_step_p), 0);
        chk("sat.ecnt",        32'(err_cnt),  32'd255);
        chk("sat.turns",       32'(turns),    32'hFF);
        chk("sat.b",           32'(b),        32'd0);

        // Legal step to b=1, then reset while the next step is in flight.
        g = 4'b0001;
        repeat (3) @(negedge clk);
        chk("pre.b",   32'(b),   32'd1);
        chk("pre.dir", 32'(dir), 32'd1);
        g = 4'b0011;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async");
        @(negedge clk);
        chk_all_zero("held");
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("rel.valid@%0d", k), 32'(valid), 32'(k >= 4));
            chk($sformatf("rel.step@%0d", k),  32'(step),  0);
            chk($sformatf("rel.err@%0d", k),   32'(err),   0);
        end
        chk("rel.b", 32'(b), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
